// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//  Shared definitions for the instruction fetch sequencer and the control FSM
//  that drives it: FSM state encodings, instruction size in bytes and the
//  width of the settle-wait counter.
package fetch_sequencer_pkg;

  localparam int CNT_W       = 4;
  localparam int INSTR_BYTES = 4;

  // State encodings are shared with the control FSM, so they are plain
  // constants with a fixed encoding rather than an enum.
  localparam logic [0:0] FS_IDLE = 1'b0;
  localparam logic [0:0] FS_WAIT = 1'b1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Clears the two low bits of a redirect target so that the PC always
  // points at a whole instruction word.
  function automatic logic [1:0] low_bits_clear();
    return 2'b00;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//  Bundles the fetch sequencer's control-side and memory-side signals.
//  slave  : the fetch sequencer itself
//  master : the control FSM plus instruction memory that surround it
//  Signals
//   fetch_req, pc_load, pc_target : control FSM -> sequencer
//   imem_rdata                    : instruction memory -> sequencer
//   imem_addr                     : sequencer -> instruction memory
//   ir, ir_valid, pc, busy,
//   misalign_err                  : sequencer -> control FSM
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              fetch_req;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic [DATA_W-1:0] imem_rdata;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              misalign_err;

  modport slave (
    input  fetch_req, pc_load, pc_target, imem_rdata,
    output imem_addr, ir, ir_valid, pc, busy, misalign_err
  );

  modport master (
    output fetch_req, pc_load, pc_target, imem_rdata,
    input  imem_addr, ir, ir_valid, pc, busy, misalign_err
  );

endinterface

// File: rtl/fetch_wait_counter.sv
// fetch_wait_counter
//  Counts down the clocks the instruction memory address must be held stable
//  before the read data is captured.
//  Ports
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : load load_val (start of a fetch)
//   load_val   : number of settle clocks
//   dec        : decrement by one while waiting (saturates at zero)
//   clear      : force to zero (fetch aborted); wins over load and dec
//   last       : high when the count is exactly one, i.e. the next edge captures
module fetch_wait_counter
  import fetch_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  cnt_t load_val,
  input  logic dec,
  input  logic clear,
  output logic last
);

  cnt_t cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - cnt_t'(1);
    end
  end

  assign last = (cnt == cnt_t'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//  Sequences instruction fetch for the multicycle processor. Owns the PC,
//  presents a registered word address to the combinational instruction
//  memory, waits WAIT_CYCLES clocks for the read data to settle, then latches
//  it into the IR and advances the PC.
//  Parameters
//   ADDR_W      : PC / byte-address width
//   DATA_W      : instruction width
//   WAIT_CYCLES : settle clocks before capture (1..15)
//   RESET_PC    : PC after reset (word aligned)
//  Ports
//   clk, rst_n  : clock and asynchronous active-low reset
//   bus (slave) : fetch_req/pc_load/pc_target from the control FSM,
//                 imem_rdata/imem_addr to instruction memory,
//                 ir/ir_valid/pc/busy/misalign_err back to the control FSM
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int               ADDR_W      = 32,
  parameter int               DATA_W      = 32,
  parameter int               WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_sequencer_if.slave bus
);

  logic [0:0]        state;
  logic [ADDR_W-1:0] tgt;
  logic              misaligned;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_clear;
  logic              cnt_last;

  // Redirect targets are forced onto a word boundary; a non-zero low pair is
  // reported but otherwise ignored.
  assign tgt        = {bus.pc_target[ADDR_W-1:2], low_bits_clear()};
  assign misaligned = |bus.pc_target[1:0];

  // A fetch starts from IDLE whenever fetch_req is high, whether or not a
  // redirect accompanies it. A redirect in WAIT aborts the fetch, so it
  // clears the counter instead of letting it reach the capture count.
  assign cnt_load  = (state == FS_IDLE) && bus.fetch_req;
  assign cnt_dec   = (state == FS_WAIT) && !bus.pc_load;
  assign cnt_clear = (state == FS_WAIT) &&  bus.pc_load;

  fetch_wait_counter u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_t'(WAIT_CYCLES)),
    .dec      (cnt_dec),
    .clear    (cnt_clear),
    .last     (cnt_last)
  );

  // Main fetch FSM with the PC, IR and address registers. ir_valid and
  // misalign_err are single-cycle pulses, so they fall back to zero unless
  // an edge explicitly raises them. In WAIT a redirect takes priority over
  // the capture so a flushed fetch never produces an instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= FS_IDLE;
      bus.pc           <= RESET_PC;
      bus.imem_addr    <= RESET_PC;
      bus.ir           <= '0;
      bus.ir_valid     <= 1'b0;
      bus.misalign_err <= 1'b0;
    end else begin
      bus.ir_valid     <= 1'b0;
      bus.misalign_err <= 1'b0;
      case (state)
        FS_IDLE: begin
          if (bus.pc_load) begin
            bus.pc           <= tgt;
            bus.misalign_err <= misaligned;
            if (bus.fetch_req) begin
              bus.imem_addr <= tgt;
              state         <= FS_WAIT;
            end
          end else if (bus.fetch_req) begin
            bus.imem_addr <= bus.pc;
            state         <= FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (bus.pc_load) begin
            bus.pc           <= tgt;
            bus.misalign_err <= misaligned;
            state            <= FS_IDLE;
          end else if (cnt_last) begin
            bus.ir       <= bus.imem_rdata;
            bus.ir_valid <= 1'b1;
            bus.pc       <= bus.imem_addr + ADDR_W'(INSTR_BYTES);
            state        <= FS_IDLE;
          end
        end
        default: begin
          state <= FS_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state == FS_WAIT);

endmodule
